// File: rtl/handshake_pkg.sv
// Shared types and helpers for the usb_clk clear-request arbiter.
// Holds the FSM encoding, the round-robin search and the counter width helper.
package handshake_pkg;

  typedef enum logic [1:0] {
    ST_RESET    = 2'd0,
    ST_IDLE     = 2'd1,
    ST_PULSE    = 2'd2,
    ST_WAIT_REL = 2'd3
  } hs_state_e;

  localparam int MAX_CH = 16;

  // Width able to hold 0..n, never narrower than one bit.
  function automatic int cnt_w(input int n);
    int w;
    w = $clog2(n + 1);
    return (w < 1) ? 1 : w;
  endfunction

  // First set bit of eligible scanning ptr, ptr+1, ... modulo n.
  // Returns ptr when nothing is eligible; callers gate on |eligible.
  function automatic int next_rr_idx(input int ptr, input logic [MAX_CH-1:0] eligible,
                                     input int n);
    int res;
    int idx;
    res = ptr;
    for (int k = MAX_CH - 1; k >= 0; k--) begin
      idx = ptr + k;
      if (idx >= n) idx = idx - n;
      if (k < n && eligible[4'(idx)]) res = idx;
    end
    return res;
  endfunction

endpackage

// File: rtl/handshake_clr_arbiter_sync.sv
// Per-bit multi-flop synchroniser with a configurable reset value.
// STAGES = 0 turns it into a wire for inputs already in the usb_clk domain.
module sync_n_ff #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic usb_clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  generate
    if (STAGES == 0) begin : g_bypass
      // clock/reset have no load in bypass mode
      logic unused_clk_rst;
      assign unused_clk_rst = usb_clk ^ rst_n;
      assign q = d;
    end else begin : g_ff
      logic [STAGES-1:0] ff;
      always_ff @(posedge usb_clk or negedge rst_n) begin
        if (!rst_n) ff <= {STAGES{RST_VAL}};
        else        ff <= STAGES'({ff, d});
      end
      assign q = ff[STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/handshake_clr_arbiter.sv
// Round-robin arbiter turning N_CH active-low clear requests into one
// registered, fixed-width active-low clear pulse each, with release timeout.
module handshake_clr_arbiter
  import handshake_pkg::*;
#(
  parameter int  N_CH           = 2,
  parameter int  SYNC_STAGES    = 2,
  parameter int  PULSE_CYCLES   = 1,
  parameter int  TIMEOUT_CYCLES = 1024,
  localparam int IDX_W          = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             usb_clk,
  input  logic             rst_n,
  input  logic [N_CH-1:0]  req_n_i,
  output logic [N_CH-1:0]  clr_n_o,
  output logic             busy_o,
  output logic [IDX_W-1:0] grant_idx_o,
  output logic [N_CH-1:0]  timeout_o,
  input  logic [N_CH-1:0]  timeout_clr_i
);

  localparam int PCW = cnt_w(PULSE_CYCLES);
  localparam int TCW = cnt_w(TIMEOUT_CYCLES);

  logic [N_CH-1:0] req_s;

  generate
    for (genvar i = 0; i < N_CH; i++) begin : g_sync
      sync_n_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync (
        .usb_clk (usb_clk),
        .rst_n   (rst_n),
        .d       (req_n_i[i]),
        .q       (req_s[i])
      );
    end
  endgenerate

  hs_state_e        state, state_nxt;
  logic [IDX_W-1:0] ptr, ptr_nxt, gidx, gidx_nxt, rr_g, ptr_inc;
  logic [PCW-1:0]   pcnt, pcnt_nxt;
  logic [TCW-1:0]   tcnt, tcnt_nxt;
  logic [N_CH-1:0]  mask, mask_nxt, tflag, tflag_nxt, clr_n, clr_n_nxt;
  logic [N_CH-1:0]  elig, g_oh, to_set;

  assign elig    = ~req_s & ~mask;
  assign rr_g    = IDX_W'(next_rr_idx(int'(ptr), MAX_CH'(elig), N_CH));
  assign g_oh    = N_CH'(1'b1) << gidx;
  assign ptr_inc = (int'(gidx) == N_CH - 1) ? '0 : gidx + 1'b1;

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    gidx_nxt  = gidx;
    pcnt_nxt  = pcnt;
    tcnt_nxt  = tcnt;
    to_set    = '0;
    // A released request re-arms its channel.
    mask_nxt  = mask & ~req_s;
    clr_n_nxt = '1;

    case (state)
      ST_RESET: state_nxt = ST_IDLE;
      ST_IDLE: begin
        if (|elig) begin
          state_nxt = ST_PULSE;
          gidx_nxt  = rr_g;
          pcnt_nxt  = '0;
        end
      end
      ST_PULSE: begin
        if (pcnt == PCW'(PULSE_CYCLES - 1)) begin
          state_nxt = ST_WAIT_REL;
          tcnt_nxt  = '0;
        end else begin
          pcnt_nxt = pcnt + 1'b1;
        end
      end
      ST_WAIT_REL: begin
        if (|(req_s & g_oh)) begin
          state_nxt = ST_IDLE;
          ptr_nxt   = ptr_inc;
        end else if (TIMEOUT_CYCLES != 0 && tcnt == TCW'(TIMEOUT_CYCLES - 1)) begin
          to_set    = g_oh;
          mask_nxt  = mask_nxt | g_oh;
          state_nxt = ST_IDLE;
          ptr_nxt   = ptr_inc;
        end else if (tcnt != {TCW{1'b1}}) begin
          tcnt_nxt = tcnt + 1'b1;
        end
      end
      default: state_nxt = ST_RESET;
    endcase

    tflag_nxt = (tflag & ~timeout_clr_i) | to_set;

    // Output flop follows next-state so the pulse starts on the PULSE entry edge.
    if (state_nxt == ST_PULSE) clr_n_nxt = ~(N_CH'(1'b1) << gidx_nxt);
  end

  always_ff @(posedge usb_clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RESET;
      ptr   <= '0;
      gidx  <= '0;
      pcnt  <= '0;
      tcnt  <= '0;
      mask  <= '0;
      tflag <= '0;
      clr_n <= '1;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      gidx  <= gidx_nxt;
      pcnt  <= pcnt_nxt;
      tcnt  <= tcnt_nxt;
      mask  <= mask_nxt;
      tflag <= tflag_nxt;
      clr_n <= clr_n_nxt;
    end
  end

  assign clr_n_o     = clr_n;
  assign busy_o      = (state == ST_PULSE) || (state == ST_WAIT_REL);
  assign grant_idx_o = gidx;
  assign timeout_o   = tflag;

endmodule

// File: tb/tb_handshake_clr_arbiter.sv
// Directed plus randomized bench for handshake_clr_arbiter with a
// transaction-level reference model (owner / remaining-pulse / wait count).
module tb_handshake_clr_arbiter;

  localparam int N  = 4;
  localparam int SS = 2;
  localparam int PC = 3;
  localparam int TC = 8;
  localparam int IW = 2;

  logic          usb_clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req_n, to_clr, clr_n_o, timeout_o;
  logic          busy_o;
  logic [IW-1:0] grant_idx_o;

  logic [1:0]    req2, clr2, to2;
  logic          busy2;
  logic [0:0]    gidx2;

  always #5 usb_clk = ~usb_clk;

  handshake_clr_arbiter #(.N_CH(N), .SYNC_STAGES(SS), .PULSE_CYCLES(PC),
                          .TIMEOUT_CYCLES(TC)) u_dut (
    .usb_clk       (usb_clk),
    .rst_n         (rst_n),
    .req_n_i       (req_n),
    .clr_n_o       (clr_n_o),
    .busy_o        (busy_o),
    .grant_idx_o   (grant_idx_o),
    .timeout_o     (timeout_o),
    .timeout_clr_i (to_clr)
  );

  handshake_clr_arbiter #(.N_CH(2), .SYNC_STAGES(0), .PULSE_CYCLES(1),
                          .TIMEOUT_CYCLES(0)) u_dut2 (
    .usb_clk       (usb_clk),
    .rst_n         (rst_n),
    .req_n_i       (req2),
    .clr_n_o       (clr2),
    .busy_o        (busy2),
    .grant_idx_o   (gidx2),
    .timeout_o     (to2),
    .timeout_clr_i (2'b00)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: who owns the grant, how much pulse is left, how long
  // we have waited for release. owner -2 = post-reset cycle, -1 = free.
  logic [N-1:0] sp [SS];
  int           owner, pleft, wcnt, ptr, m_last;
  logic [N-1:0] m_mask, m_to;

  task automatic model_reset();
    for (int k = 0; k < SS; k++) sp[k] = '1;
    owner = -2; pleft = 0; wcnt = 0; ptr = 0; m_last = 0;
    m_mask = '0; m_to = '0;
  endtask

  task automatic model_edge();
    logic [N-1:0] rs, tset;
    rs   = sp[SS-1];
    tset = '0;
    for (int k = SS - 1; k > 0; k--) sp[k] = sp[k-1];
    sp[0] = req_n;
    if (owner == -2) begin
      owner = -1;
    end else if (owner == -1) begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (ptr + k) % N;
        if (!rs[c] && !m_mask[c]) begin
          owner = c; pleft = PC; m_last = c;
          break;
        end
      end
    end else if (pleft > 0) begin
      pleft--;
      wcnt = 0;
    end else if (rs[owner]) begin
      ptr = (owner + 1) % N; owner = -1;
    end else if (wcnt == TC - 1) begin
      tset[owner] = 1'b1;
      ptr = (owner + 1) % N; owner = -1;
    end else begin
      wcnt++;
    end
    m_mask = (m_mask & ~rs) | tset;
    m_to   = (m_to & ~to_clr) | tset;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h, required %0h", tag, obs, exp);
  endtask

  task automatic check_model();
    logic [N-1:0] e;
    e = '1;
    if (owner >= 0 && pleft > 0) e[owner] = 1'b0;
    chk("clr_n", 32'(clr_n_o), 32'(e));
    chk("busy", 32'(busy_o), 32'(owner >= 0));
    chk("grant_idx", 32'(grant_idx_o), 32'(m_last));
    chk("timeout", 32'(timeout_o), 32'(m_to));
  endtask

  task automatic step();
    @(posedge usb_clk);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  // Wait for any running pulse to end, then count edges until the next one.
  task automatic wait_pulse(input string tag, output int n);
    n = 0;
    while (clr_n_o !== '1 && n < 40) begin step(); n++; end
    n = 0;
    while (clr_n_o === '1 && n < 40) begin step(); n++; end
    chk({tag, "_seen"}, 32'(clr_n_o !== '1), 32'd1);
  endtask

  initial begin
    int  n, w;
    bit  found;
    rst_n = 1'b0; req_n = '1; to_clr = '0; req2 = '1;
    model_reset();
    #12;
    chk("rst_clr", 32'(clr_n_o), 32'hF);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_gidx", 32'(grant_idx_o), 32'd0);
    chk("rst_to", 32'(timeout_o), 32'd0);
    chk("rst_clr2", 32'(clr2), 32'h3);
    @(negedge usb_clk) rst_n = 1'b1;
    step();

    // 2-channel, no synchroniser, 1-cycle pulse, timeout disabled
    req2 = 2'b10;
    step();
    chk("t1_clr_low", 32'(clr2), 32'h2);
    chk("t1_busy", 32'(busy2), 32'd1);
    chk("t1_gidx", 32'(gidx2), 32'd0);
    step();
    chk("t1_clr_high", 32'(clr2), 32'h3);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t1_busy_hold", 32'(busy2), 32'd1);
    end
    req2 = 2'b11;
    step();
    chk("t1_idle", 32'(busy2), 32'd0);
    req2 = 2'b01;
    idle(30);
    chk("t1_no_timeout", 32'(to2), 32'd0);
    chk("t1_still_busy", 32'(busy2), 32'd1);
    req2 = 2'b11;
    step();

    // All four at once, served 0..3, twice (pointer wraps)
    for (int r = 0; r < 2; r++) begin
      req_n = '0;
      for (int j = 0; j < N; j++) begin
        wait_pulse("t2", n);
        chk("t2_order", 32'(grant_idx_o), 32'(j));
        req_n[j] = 1'b1;
      end
      idle(8);
    end

    // Latency and pulse width on channel 2
    req_n = 4'b1011;
    wait_pulse("t3", n);
    chk("t3_latency", 32'(n), 32'(SS + 1));
    chk("t3_clr", 32'(clr_n_o), 32'hB);
    w = 0;
    while (clr_n_o[2] === 1'b0 && w < 10) begin step(); w++; end
    chk("t3_width", 32'(w), 32'(PC));
    req_n = '1;
    idle(6);

    // Stuck channel 1 times out; channel 0 keeps being served
    req_n[1] = 1'b0;
    wait_pulse("t4", n);
    chk("t4_gidx1", 32'(grant_idx_o), 32'd1);
    n = 0;
    while (timeout_o[1] !== 1'b1 && n < 30) begin step(); n++; end
    chk("t4_timeout", 32'(timeout_o[1]), 32'd1);
    for (int r = 0; r < 3; r++) begin
      req_n[0] = 1'b0;
      wait_pulse("t4b", n);
      chk("t4_ch0", 32'(grant_idx_o), 32'd0);
      req_n[0] = 1'b1;
      idle(6);
    end
    to_clr = 4'b0010;
    step();
    to_clr = '0;
    chk("t5_lone_clr_a", 32'(timeout_o[1]), 32'd0);
    req_n[1] = 1'b1;
    idle(4);
    req_n[1] = 1'b0;
    wait_pulse("t4c", n);
    chk("t4_regrant1", 32'(grant_idx_o), 32'd1);

    // Timeout and clear in the same cycle: set wins
    found = 1'b0;
    for (int k = 0; k < 60 && !found; k++) begin
      if (owner == 1 && pleft == 0 && wcnt == TC - 1 && sp[SS-1][1] == 1'b0) begin
        to_clr = 4'b0010;
        found  = 1'b1;
      end
      step();
      to_clr = '0;
    end
    chk("t5_hit", 32'(found), 32'd1);
    chk("t5_setwins", 32'(timeout_o[1]), 32'd1);
    to_clr = 4'b0010;
    step();
    to_clr = '0;
    chk("t5_lone_clr_b", 32'(timeout_o[1]), 32'd0);
    req_n = '1;
    idle(5);

    // Reset during a pulse
    req_n = 4'b0111;
    wait_pulse("t6", n);
    req_n = 4'b0101;
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_clr", 32'(clr_n_o), 32'hF);
    chk("t6_busy", 32'(busy_o), 32'd0);
    chk("t6_gidx", 32'(grant_idx_o), 32'd0);
    model_reset();
    @(negedge usb_clk) rst_n = 1'b1;
    wait_pulse("t6b", n);
    chk("t6_latency", 32'(n), 32'(SS + 1));
    chk("t6_from_ptr0", 32'(grant_idx_o), 32'd1);
    req_n = '1;
    idle(8);

    // Randomized traffic against the model
    for (int k = 0; k < 600; k++) begin
      for (int c = 0; c < N; c++)
        if ($urandom_range(7) == 0) req_n[c] = ~req_n[c];
      to_clr = ($urandom_range(15) == 0) ? N'($urandom) : '0;
      step();
    end
    req_n = '1; to_clr = '0;
    idle(12);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/handshake_clr_arbiter.md
Name: handshake_clr_arbiter

Overview:
- Parametrised successor to the two-channel usb_clk handshake control unit.
- Serves N_CH active-low "clear valid" requests arriving from the FPGA clock domain through a configurable synchroniser.
- Arbitrates the requests round-robin and issues one registered, active-low clear pulse of programmable width per request to the usb_clk status registers.
- Waits for each request to be released; a sticky per-channel timeout flag plus a channel mask prevent a stuck request from blocking the others.

Parameters:
- N_CH, 2, number of request/clear channels (1..16).
- SYNC_STAGES, 2, flops in the input synchroniser; 0 = bypass (inputs already in usb_clk domain).
- PULSE_CYCLES, 1, clear pulse width in usb_clk cycles (>=1).
- TIMEOUT_CYCLES, 1024, max cycles to wait for request release; 0 disables timeout.
- IDX_W (localparam), max(1, clog2(N_CH)), grant index width.

Ports:
- usb_clk  in  1  clock, 96 MHz USB domain.
- rst_n  in  1  reset, asynchronous, active-low.
- req_n_i  in  N_CH  active-low clear requests from the bridge, FPGA domain.
- clr_n_o  out  N_CH  active-low clear pulses to the status registers, registered.
- busy_o  out  1  high while a grant is active (PULSE or WAIT_REL).
- grant_idx_o  out  IDX_W  index of the current or most recent grant.
- timeout_o  out  N_CH  sticky per-channel timeout flags.
- timeout_clr_i  in  N_CH  usb_clk-domain, write-1-to-clear for timeout_o.

Behaviour:
- Reset (async assert, sync deassert via usb_clk):
  - clr_n_o = all 1, busy_o = 0, grant_idx_o = 0, timeout_o = 0.
  - RR pointer = 0, mask = 0, state = RESET, synchroniser flops = 1.
- Reset mid-operation aborts any pulse immediately; clr_n_o returns to 1 asynchronously.
- req_s = req_n_i after SYNC_STAGES flops; the synchroniser resets to 1 (inactive).
- States:
  - RESET -> IDLE unconditionally after 1 cycle; requests are ignored in RESET.
  - IDLE:
    - eligible[i] = ~req_s[i] & ~mask[i].
    - If any channel is eligible, grant g = first eligible index scanning ptr, ptr+1, ... modulo N_CH.
    - Go to PULSE; grant_idx_o = g; pulse counter = 0.
  - PULSE:
    - clr_n_o[g] = 0 for exactly PULSE_CYCLES cycles, all other bits 1.
    - Then go to WAIT_REL; timeout counter = 0.
  - WAIT_REL:
    - If req_s[g] == 1: go to IDLE and set ptr = (g+1) mod N_CH.
    - Else if TIMEOUT_CYCLES != 0 and counter == TIMEOUT_CYCLES-1: set timeout_o[g] = 1 and mask[g] = 1, go to IDLE, set ptr = (g+1) mod N_CH.
    - Else increment the counter (saturating).
  - Illegal state -> RESET.
- clr_n_o is driven from a flop loaded from next-state decode, so it goes low on the same edge the state enters PULSE.
- Latency:
  - req_n_i low before edge 0 -> clr_n_o low after edge SYNC_STAGES+1.
  - SYNC_STAGES=0 gives a 1-cycle latency.
- At most one clr_n_o bit is low at any time, and only in PULSE.
- Minimum per-request occupancy: PULSE_CYCLES + 1 cycles (release already high on WAIT_REL entry).
- mask[i] clears on any cycle with req_s[i] == 1; a channel re-arms only after release.
- timeout_o[i] clears on timeout_clr_i[i] == 1. If set and clear occur in the same cycle, set wins.
- A request that drops then rises within one cycle while the channel is not granted is missed. The bridge must hold each request until it sees clear.
- N_CH=1: the pointer is constant 0 and grant_idx_o is 1 bit = 0.

Decomposition:
- handshake_pkg:
  - state enum {RESET, IDLE, PULSE, WAIT_REL}.
  - Function next_rr_idx(ptr, eligible, N) for the round-robin search.
  - Function cnt_w(n) returning max(1, clog2(n+1)).
- One sub-module: sync_n_ff, per-bit synchroniser.
  - Parameters STAGES and RST_VAL (1 here).
  - Bypass when STAGES=0.

Test Plan:
1. N_CH=2, SYNC=0, PULSE=1: hold req_n_i[0]=0 for 5 cycles -> clr_n_o=2'b10 for exactly 1 cycle, 1 edge after the request is sampled; busy_o high until req_n_i[0] returns to 1, then IDLE.
2. N_CH=4, SYNC=2: assert req_n_i=4'b0000 simultaneously and release each channel after its clear -> grants in order 0, 1, 2, 3; assert again -> order starts at 0 again after ptr wraps from 3.
3. PULSE_CYCLES=3: single request on channel 2 -> clr_n_o[2] low for exactly 3 consecutive cycles; latency SYNC_STAGES+1 edges.
4. TIMEOUT_CYCLES=8: hold req_n_i[1]=0 forever while req_n_i[0] pulses -> timeout_o[1]=1 after the 8th WAIT_REL cycle; channel 1 is never re-granted; channel 0 continues to be served; release ch1 and request again -> ch1 granted.
5. Same-cycle timeout_clr_i[1]=1 and timeout event on ch1 -> timeout_o[1] stays 1; a later lone timeout_clr_i[1] -> timeout_o[1]=0.
6. Assert rst_n=0 during PULSE -> clr_n_o=all 1 immediately (asynchronously); after release, 1 RESET cycle, then a pending request is served with normal latency from ptr 0.
